// File: rtl/rsa_pkg.sv
// rsa_pkg: shared RSA datapath width and mod_mult state encoding
package rsa_pkg;

    localparam int RSA_W = 32;

    typedef enum logic {
        IDLE,
        CALC
    } mm_state_t;

endpackage

// File: rtl/mod_mult_step.sv
// mod_mult_step: one interleaved step, R' = (2R + bit*a) mod m for R, a < m
module mod_mult_step
    import rsa_pkg::*;
#(
    parameter int W = RSA_W
) (
    input  logic [W-1:0] r,
    input  logic [W-1:0] a_q,
    input  logic [W-1:0] m_q,
    input  logic         b_bit,
    output logic [W-1:0] r_nxt
);

    logic [W+1:0] mx, t0, t1, t2;

    // 2R + a < 3m fits in W+2 bits, so two conditional subtracts bring it back below m
    always_comb begin
        mx    = {2'b00, m_q};
        t0    = {1'b0, r, 1'b0} + (b_bit ? {2'b00, a_q} : '0);
        t1    = (t0 >= mx) ? t0 - mx : t0;
        t2    = (t1 >= mx) ? t1 - mx : t1;
        r_nxt = t2[W-1:0];
    end

endmodule

// File: rtl/mod_mult.sv
// mod_mult: iterative MSB-first interleaved modular multiplier, result = (a*b) mod m
module mod_mult
    import rsa_pkg::*;
#(
    parameter int W  = RSA_W,
    parameter int CW = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] m,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] result
);

    mm_state_t     state;
    logic [W-1:0]  a_q, b_q, m_q, acc, acc_nxt;
    logic [CW-1:0] idx;
    logic          err_pend;

    mod_mult_step #(.W(W)) u_step (
        .r    (acc),
        .a_q  (a_q),
        .m_q  (m_q),
        .b_bit(b_q[idx]),
        .r_nxt(acc_nxt)
    );

    // Accept in IDLE (illegal operands report one edge later), then one multiplier bit per edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            acc      <= '0;
            idx      <= '0;
            err_pend <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            result   <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (err_pend) begin
                    err_pend <= 1'b0;
                    done     <= 1'b1;
                    err      <= 1'b1;
                    result   <= '0;
                    busy     <= 1'b0;
                end else if (start) begin
                    a_q  <= a;
                    b_q  <= b;
                    m_q  <= m;
                    acc  <= '0;
                    idx  <= CW'(W - 1);
                    busy <= 1'b1;
                    err  <= 1'b0;
                    if (m == '0 || a >= m) err_pend <= 1'b1;
                    else state <= CALC;
                end
            end else begin
                acc <= acc_nxt;
                if (idx == '0) begin
                    result <= acc_nxt;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end else begin
                    idx <= idx - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mod_mult.sv
// tb_mod_mult: directed and random checks of mod_mult against an arithmetic model
module tb_mod_mult;
    import rsa_pkg::*;

    localparam int W  = RSA_W;
    localparam int W8 = 8;

    logic         clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [W-1:0] a = '0, b = '0, m = '0;
    logic         busy, done, err;
    logic [W-1:0] result;

    logic          start8 = 1'b0;
    logic [W8-1:0] a8 = '0, b8 = '0, m8 = '0;
    logic          busy8, done8, err8;
    logic [W8-1:0] result8;

    logic [3:0] sr = '0, sa = '0, sm = '0, snxt;
    logic       sbit = 1'b0;

    int passed = 0, total = 0;

    mod_mult #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .m(m),
        .busy(busy), .done(done), .err(err), .result(result)
    );

    mod_mult #(.W(W8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .m(m8),
        .busy(busy8), .done(done8), .err(err8), .result(result8)
    );

    mod_mult_step #(.W(4)) ustep (
        .r(sr), .a_q(sa), .m_q(sm), .b_bit(sbit), .r_nxt(snxt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: an accepted request finishes W edges later (1 for illegal operands) with (a*b)%m
    int           cyc = 0, fin = 0;
    logic [W-1:0] exp_res = '0, pend_res = '0;
    logic         exp_err = 1'b0, pend_err = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc = 0; fin = 0; exp_res = '0; exp_err = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
        end else begin
            cyc++;
            if (start && cyc - 1 >= fin) begin
                pend_err = (m == '0) || (a >= m);
                fin      = cyc + (pend_err ? 1 : W);
                pend_res = pend_err ? '0 : W'((64'(a) * 64'(b)) % 64'(m));
                exp_err  = 1'b0;
            end
            exp_busy = cyc < fin;
            exp_done = cyc == fin;
            if (exp_done) begin
                exp_res = pend_res;
                exp_err = pend_err;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", busy, exp_busy);
            chk("done", done, exp_done);
            chk("err", err, exp_err);
            chk("result", result, exp_res);
        end
    end

    task automatic go(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [W-1:0] mv);
        a = av; b = bv; m = mv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < W + 5) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", done, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [W-1:0] rm;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_result", result, 0);
        chk("rst_busy8", busy8, 0);
        rst = 1'b0;
        @(negedge clk);

        go(7, 5, 13); wait_done(n);
        chk("basic_lat", n, W);
        chk("basic_res", result, 9);
        chk("basic_err", err, 0);

        go(0, 9, 1); wait_done(n);
        chk("m1_res", result, 0);
        chk("m1_err", err, 0);

        go(32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF); wait_done(n);
        chk("wide_res", result, 1);

        go(3, 4, 0); wait_done(n);
        chk("m0_lat", n, 1);
        chk("m0_err", err, 1);
        chk("m0_res", result, 0);
        @(negedge clk);
        chk("err_held", err, 1);

        go(13, 2, 13); wait_done(n);
        chk("a_eq_m_err", err, 1);

        go(7, 5, 13);
        repeat (5) @(negedge clk);
        a = 1; b = 1; m = 3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        chk("ignore_res", result, 9);

        go(2, 3, 5); wait_done(n);
        chk("b2b_first", result, 1);
        go(4, 4, 7); wait_done(n);
        chk("b2b_lat", n, W);
        chk("b2b_res", result, 2);

        go(7, 5, 13);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        go(2, 3, 5); wait_done(n);
        chk("post_rst_res", result, 1);

        for (int k = 0; k < 150; k++) begin
            rm = $urandom;
            if (rm == '0) rm = 1;
            go($urandom % rm, $urandom, rm);
            wait_done(n);
            chk("rand_lat", n, W);
        end

        for (int k = 0; k < 300; k++) begin
            m8 = W8'($urandom_range(1, 255));
            a8 = (k % 50 == 7) ? m8 : W8'($urandom_range(0, int'(m8) - 1));
            b8 = W8'($urandom_range(0, 255));
            start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0;
            n = 0;
            while (!done8 && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (a8 >= m8) begin
                chk("w8_err_lat", n, 1);
                chk("w8_err", err8, 1);
                chk("w8_err_res", result8, 0);
            end else begin
                chk("w8_lat", n, W8);
                chk("w8_err", err8, 0);
                chk("w8_res", result8, (int'(a8) * int'(b8)) % int'(m8));
            end
        end

        for (int mi = 1; mi < 16; mi++)
            for (int ai = 0; ai < mi; ai++)
                for (int ri = 0; ri < mi; ri++)
                    for (int bi = 0; bi < 2; bi++) begin
                        sm = 4'(mi); sa = 4'(ai); sr = 4'(ri); sbit = bi[0];
                        #1;
                        chk("step4", snxt, (2 * ri + bi * ai) % mi);
                    end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
